// File: rtl/fredkin_alu_pkg.sv
// Shared op codes, FSM state constants and op classification helpers for the
// Fredkin ALU scheduler. Optional two-pass ops (XOR/XNOR) are enabled by
// defining FREDKIN_ALU_XOR_EN.
package fredkin_alu_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned ST_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
    localparam logic [OP_W-1:0] OP_MUX  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

`ifdef FREDKIN_ALU_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ISSUE1 = 3'd1;
    localparam state_t ST_WAIT1  = 3'd2;
`ifdef FREDKIN_ALU_XOR_EN
    localparam state_t ST_ISSUE2 = 3'd3;
    localparam state_t ST_WAIT2  = 3'd4;
`endif
    localparam state_t ST_RESP   = 3'd5;

    // Ops needing a second gate pass (only when the XOR path is built in)
    function automatic logic op_is_two_pass(input logic [OP_W-1:0] op);
        return XOR_EN && ((op == OP_XOR) || (op == OP_XNOR));
    endfunction

    // Ops the datapath can execute; everything else answers with rsp_err
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_MUX) || op_is_two_pass(op);
    endfunction

endpackage

// File: rtl/fredkin_rr_arb.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping cyclically. Produces one-hot gnt and encoded idx.
module fredkin_rr_arb #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic           w_found;
    logic [IDW-1:0] w_k;

    // Scan from ptr upward; the first hit wins
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_k = IDW'((32'(ptr) + i) % NREQ);
            if (en && !w_found && req[w_k]) begin
                gnt[w_k] = 1'b1;
                idx      = w_k;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fredkin_alu_sched.sv
// Shares one registered Fredkin gate among NREQ requesters: round-robin
// accept, one or two gate passes per op, tagged response with backpressure.
// Optional feature macro: FREDKIN_ALU_XOR_EN (adds XOR/XNOR two-pass ops).
module fredkin_alu_sched
    import fredkin_alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [3*NREQ-1:0]       req_op,
    input  logic [W*NREQ-1:0]       req_x,
    input  logic [W*NREQ-1:0]       req_y,
    input  logic [W*NREQ-1:0]       req_z,
    output logic [W-1:0]            g_a,
    output logic [W-1:0]            g_b,
    output logic [W-1:0]            g_c,
    input  logic [W-1:0]            g_q,
    input  logic [W-1:0]            g_r,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_data,
    output logic [W-1:0]            rsp_garb,
    output logic                    rsp_err
);

    localparam int unsigned IDW = $clog2(NREQ);

    // State and latched request
    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [OP_W-1:0] r_op;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [W-1:0]    r_z;
    logic [IDW-1:0]  r_id;
`ifdef FREDKIN_ALU_XOR_EN
    logic [W-1:0]    r_t;
    logic [W-1:0]    w_t_nxt;
`endif

    // Response registers
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_data;
    logic [W-1:0]    r_rsp_garb;

    // Next-state values
    state_t          w_state_nxt;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [OP_W-1:0] w_op_nxt;
    logic [W-1:0]    w_x_nxt;
    logic [W-1:0]    w_y_nxt;
    logic [W-1:0]    w_z_nxt;
    logic [IDW-1:0]  w_id_nxt;
    logic            w_rsp_valid_nxt;
    logic            w_rsp_err_nxt;
    logic [IDW-1:0]  w_rsp_id_nxt;
    logic [W-1:0]    w_rsp_data_nxt;
    logic [W-1:0]    w_rsp_garb_nxt;
    logic            w_finish;

    // Arbitration and selected request payload
    logic            w_arb_en;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic [OP_W-1:0] w_sel_op;
    logic [W-1:0]    w_sel_x;
    logic [W-1:0]    w_sel_y;
    logic [W-1:0]    w_sel_z;

    // Only IDLE may accept, and nothing is accepted while reset is held
    assign w_arb_en = (r_state == ST_IDLE) && rst_n;

    fredkin_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req  (req_valid),
        .ptr  (r_ptr),
        .en   (w_arb_en),
        .gnt  (w_gnt),
        .idx  (w_idx)
    );

    assign req_ready = w_gnt;

    // One-hot select of the granted requester's payload
    always_comb begin
        w_sel_op = '0;
        w_sel_x  = '0;
        w_sel_y  = '0;
        w_sel_z  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_op = req_op[OP_W*i +: OP_W];
                w_sel_x  = req_x[W*i +: W];
                w_sel_y  = req_y[W*i +: W];
                w_sel_z  = req_z[W*i +: W];
            end
        end
    end

    // Gate operand decode: non-zero only while issuing a pass
    always_comb begin
        g_a = '0;
        g_b = '0;
        g_c = '0;
        case (r_state)
            ST_ISSUE1: begin
                case (r_op)
                    OP_AND: begin g_a = r_x; g_b = r_y; g_c = '0;  end
                    OP_OR:  begin g_a = r_x; g_b = '1;  g_c = r_y; end
                    OP_NOT: begin g_a = r_x; g_b = '0;  g_c = '1;  end
                    OP_MUX: begin g_a = r_z; g_b = r_y; g_c = r_x; end
                    // XOR/XNOR first pass computes t = ~y
                    default: begin g_a = r_y; g_b = '0; g_c = '1; end
                endcase
            end
`ifdef FREDKIN_ALU_XOR_EN
            ST_ISSUE2: begin
                g_a = r_x;
                if (r_op == OP_XOR) begin
                    g_b = r_t;
                    g_c = r_y;
                end else begin
                    g_b = r_y;
                    g_c = r_t;
                end
            end
`endif
            default: begin
                g_a = '0;
                g_b = '0;
                g_c = '0;
            end
        endcase
    end

    // Next-state and register-update logic
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_op_nxt        = r_op;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_z_nxt         = r_z;
        w_id_nxt        = r_id;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_garb_nxt  = r_rsp_garb;
        w_finish        = 1'b0;
`ifdef FREDKIN_ALU_XOR_EN
        w_t_nxt         = r_t;
`endif

        case (r_state)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_op_nxt  = w_sel_op;
                    w_x_nxt   = w_sel_x;
                    w_y_nxt   = w_sel_y;
                    w_z_nxt   = w_sel_z;
                    w_id_nxt  = w_idx;
                    w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
                    if (op_is_legal(w_sel_op)) begin
                        w_state_nxt = ST_ISSUE1;
                    end else begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_id_nxt    = w_idx;
                        w_rsp_data_nxt  = '0;
                        w_rsp_garb_nxt  = '0;
                    end
                end
            end
            ST_ISSUE1: begin
                w_state_nxt = ST_WAIT1;
            end
            ST_WAIT1: begin
`ifdef FREDKIN_ALU_XOR_EN
                if (op_is_two_pass(r_op)) begin
                    w_t_nxt     = g_r;
                    w_state_nxt = ST_ISSUE2;
                end else begin
                    w_finish = 1'b1;
                end
`else
                w_finish = 1'b1;
`endif
            end
`ifdef FREDKIN_ALU_XOR_EN
            ST_ISSUE2: begin
                w_state_nxt = ST_WAIT2;
            end
            ST_WAIT2: begin
                w_finish = 1'b1;
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Final gate pass: capture R as data, Q as reversibility garbage
        if (w_finish) begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b0;
            w_rsp_id_nxt    = r_id;
            w_rsp_data_nxt  = g_r;
            w_rsp_garb_nxt  = g_q;
        end
    end

    // State, request and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_op        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_garb  <= '0;
`ifdef FREDKIN_ALU_XOR_EN
            r_t         <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_op        <= w_op_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_z         <= w_z_nxt;
            r_id        <= w_id_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_garb  <= w_rsp_garb_nxt;
`ifdef FREDKIN_ALU_XOR_EN
            r_t         <= w_t_nxt;
`endif
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_garb  = r_rsp_garb;

endmodule

// File: tb/tb_fredkin_alu_sched.sv
// Self-checking bench for fredkin_alu_sched: directed scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_fredkin_alu_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned IDW  = $clog2(NREQ);

`ifdef FREDKIN_ALU_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_op;
    logic [W*NREQ-1:0]    req_x, req_y, req_z;
    logic [W-1:0]         g_a, g_b, g_c, g_q, g_r;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_data, rsp_garb;
    logic                 rsp_err;

    // Requester-side drive values
    logic                 d_v  [NREQ];
    logic [2:0]           d_op [NREQ];
    logic [W-1:0]         d_x  [NREQ];
    logic [W-1:0]         d_y  [NREQ];
    logic [W-1:0]         d_z  [NREQ];

    // Model state
    bit                   m_busy;
    int                   m_wait;
    int                   m_ptr;
    int                   m_last_g;
    logic [W-1:0]         e_data, e_garb;
    logic                 e_err;
    int                   e_id;

    // Observations of the current op
    bit                   o_seen;
    int                   o_lat;
    logic [W-1:0]         o_data, o_garb;
    logic                 o_err;
    int                   o_id;
    int                   cyc;
    int                   g_cyc;
    int                   gq[$];

    int                   n_cmp = 0;
    int                   n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]      = d_v[i];
            req_op[3*i +: 3]  = d_op[i];
            req_x[W*i +: W]   = d_x[i];
            req_y[W*i +: W]   = d_y[i];
            req_z[W*i +: W]   = d_z[i];
        end
    end

    // Fredkin gate with one cycle of registered latency
    always @(posedge clk) begin
        g_q <= (g_a & g_c) | (~g_a & g_b);
        g_r <= (g_a & g_b) | (~g_a & g_c);
    end

    fredkin_alu_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_z     (req_z),
        .g_a       (g_a),
        .g_b       (g_b),
        .g_c       (g_c),
        .g_q       (g_q),
        .g_r       (g_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_garb  (rsp_garb),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected result, garbage, error and accept-to-response latency per op
    function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] x, y, z,
                                   output logic [W-1:0] d, output logic [W-1:0] g,
                                   output logic err, output int lat);
        d = '0; g = '0; err = 1'b0; lat = 3;
        case (op)
            3'd0: begin d = x & y;               g = ~x & y;               end
            3'd1: begin d = x | y;               g = ~x | y;               end
            3'd2: begin d = ~x;                  g = x;                    end
            3'd3: begin d = (z & y) | (~z & x);  g = (z & x) | (~z & y);   end
            3'd4: if (XOR_EN) begin d = x ^ y;    g = ~(x ^ y); lat = 5; end
                  else begin err = 1'b1; lat = 1; end
            3'd5: if (XOR_EN) begin d = ~(x ^ y); g = x ^ y;    lat = 5; end
                  else begin err = 1'b1; lat = 1; end
            default: begin err = 1'b1; lat = 1; end
        endcase
    endfunction

    function automatic int arb(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs at the falling edge, advance the model,
    // then return just after the next rising edge for new drive values
    task automatic step();
        int gi;
        int lat;
        logic [NREQ-1:0] exp_rdy;
        bit exp_v;
        @(negedge clk);
        cyc++;
        m_last_g = -1;
        if (!rst_n) begin
            chk("rst_ctl", 64'({req_ready, rsp_valid, rsp_err, rsp_id}), 64'd0);
            chk("rst_dat", 64'(rsp_data | rsp_garb | g_a | g_b | g_c), 64'd0);
            m_busy = 1'b0;
            m_wait = 0;
            m_ptr  = 0;
        end else begin
            gi      = m_busy ? -1 : arb(req_valid, m_ptr);
            exp_rdy = (gi >= 0) ? NREQ'(1) << gi : '0;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            exp_v = m_busy && (m_wait == 0);
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            if (rsp_valid && !o_seen) begin
                o_seen = 1'b1;
                o_lat  = cyc - g_cyc;
                o_data = rsp_data;
                o_garb = rsp_garb;
                o_err  = rsp_err;
                o_id   = int'(rsp_id);
            end
            if (exp_v) begin
                chk("rsp_id",   64'(rsp_id),   64'(e_id));
                chk("rsp_data", 64'(rsp_data), 64'(e_data));
                chk("rsp_garb", 64'(rsp_garb), 64'(e_garb));
                chk("rsp_err",  64'(rsp_err),  64'(e_err));
                chk("g_idle",   64'(g_a | g_b | g_c), 64'd0);
            end
            if (exp_v && rsp_ready) m_busy = 1'b0;
            else if (m_busy && m_wait > 0) m_wait--;
            if (gi >= 0) begin
                ref_op(d_op[gi], d_x[gi], d_y[gi], d_z[gi], e_data, e_garb, e_err, lat);
                e_id     = gi;
                m_busy   = 1'b1;
                m_wait   = lat - 1;
                m_ptr    = (gi + 1) % NREQ;
                m_last_g = gi;
                o_seen   = 1'b0;
                g_cyc    = cyc;
                gq.push_back(gi);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] x, y, z);
        d_v[i] = 1'b1; d_op[i] = op; d_x[i] = x; d_y[i] = y; d_z[i] = z;
    endtask

    task automatic wait_rsp(input string tag);
        for (int k = 0; k < 30 && !o_seen; k++) step();
        if (!o_seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && m_busy; k++) step();
        if (m_busy) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int c0;
        rst_n = 1'b0; rsp_ready = 1'b0; cyc = 0; g_cyc = 0; o_seen = 1'b0;
        m_busy = 1'b0; m_wait = 0; m_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            d_v[i] = 1'b0; d_op[i] = '0; d_x[i] = '0; d_y[i] = '0; d_z[i] = '0;
        end
        @(posedge clk); #1;
        step(); step();
        rst_n = 1'b1;
        step();

        // AND on requester 0
        rsp_ready = 1'b1;
        set_req(0, 3'd0, 32'hF0F0_1234, 32'hFF00_FF00, 32'h0);
        step(); d_v[0] = 1'b0;
        wait_rsp("and");
        chk("and_lat",  64'(o_lat),  64'd3);
        chk("and_id",   64'(o_id),   64'd0);
        chk("and_data", 64'(o_data), 64'hF000_1200);
        chk("and_garb", 64'(o_garb), 64'h0F00_ED00);
        drain();

        // XOR: two passes when enabled, illegal otherwise
        set_req(0, 3'd4, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'h0);
        step(); d_v[0] = 1'b0;
        wait_rsp("xor");
        chk("xor_lat",  64'(o_lat),  XOR_EN ? 64'd5 : 64'd1);
        chk("xor_data", 64'(o_data), XOR_EN ? 64'hA5A5_5A5A : 64'd0);
        chk("xor_err",  64'(o_err),  XOR_EN ? 64'd0 : 64'd1);
        drain();

        // Backpressure: response held 10 cycles, next requester waits
        set_req(1, 3'd1, 32'h1234_0000, 32'h0000_5678, 32'h0);
        step(); d_v[1] = 1'b0;
        rsp_ready = 1'b0;
        set_req(2, 3'd2, 32'h00FF_00FF, 32'h0, 32'h0);
        repeat (12) step();
        chk("bp_data", 64'(rsp_data), 64'h1234_5678);
        rsp_ready = 1'b1;
        step();
        c0 = cyc;
        step();
        chk("bp_regrant_id",  64'(m_last_g), 64'd2);
        chk("bp_regrant_cyc", 64'(g_cyc),    64'(c0 + 1));
        d_v[2] = 1'b0;
        wait_rsp("bp2");
        chk("not_data", 64'(o_data), 64'hFF00_FF00);
        drain();

        // Reset during WAIT1 of a MUX
        set_req(1, 3'd3, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_0000);
        step(); d_v[1] = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("rst_noresp", 64'(o_seen), 64'd0);

        // Fairness from pointer 0 with all requesters held valid
        gq.delete();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 3'(i), $urandom, $urandom, $urandom);
        for (int k = 0; k < 60 && gq.size() < 5; k++) step();
        if (gq.size() < 5) chk("fair_timeout", 64'(gq.size()), 64'd5);
        else for (int k = 0; k < 5; k++) chk("fair_order", 64'(gq[k]), 64'(k % NREQ));
        for (int i = 0; i < NREQ; i++) d_v[i] = 1'b0;
        drain();

        // Illegal op on req2 while req3 also waits
        gq.delete();
        set_req(2, 3'd7, 32'hDEAD_BEEF, 32'h1, 32'h2);
        set_req(3, 3'd0, 32'hFFFF_FFFF, 32'h1357_9BDF, 32'h0);
        step(); d_v[2] = 1'b0;
        wait_rsp("ill");
        chk("ill_lat",  64'(o_lat),  64'd1);
        chk("ill_err",  64'(o_err),  64'd1);
        chk("ill_id",   64'(o_id),   64'd2);
        chk("ill_data", 64'(o_data | o_garb), 64'd0);
        for (int k = 0; k < 10 && gq.size() < 2; k++) step();
        d_v[3] = 1'b0;
        if (gq.size() < 2) chk("ill_next_timeout", 64'(gq.size()), 64'd2);
        else chk("ill_next", 64'(gq[1]), 64'd3);
        drain();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!d_v[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
                else if (d_v[i] && $urandom_range(0, 15) == 0)
                    d_v[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            if (m_last_g >= 0) d_v[m_last_g] = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) d_v[i] = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
